// File: rtl/video_pkg.sv
// Shared types and widths for the video overlay stages.
package video_pkg;
  localparam int COORD_W = 13;
  localparam int FCNT_W  = 16;

  typedef logic [COORD_W-1:0] coord_t;
  localparam coord_t COORD_MAX = '1;

  typedef enum logic {WAIT_SOF, ACTIVE} vstate_e;
endpackage

// File: rtl/video_box_overlay_if.sv
// AXI4-Stream video beat bundle: pixel, SOF (tuser) and EOL (tlast).
interface video_box_overlay_if #(
  parameter int DATAW = 24
);
  logic [DATAW-1:0] tdata;
  logic             tvalid;
  logic             tready;
  logic             tuser;
  logic             tlast;

  modport master (output tdata, tvalid, tuser, tlast, input tready);
  modport slave  (input tdata, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/video_box_overlay_axis_reg_slice.sv
// Single-stage stream output register; the payload is held while the sink stalls.
module axis_reg_slice #(
  parameter int W = 26
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end
endmodule

// File: rtl/video_box_overlay.sv
// Draws the border of a programmable rectangle over an AXI4-Stream video feed
// and checks SOF/EOL framing, counting frames.
module video_box_overlay
  import video_pkg::*;
#(
  parameter int DATAW  = 24,
  parameter int SCRW   = 1920,
  parameter int SCRH   = 1080,
  parameter int BORDER = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  coord_t              box_x,
  input  coord_t              box_y,
  input  coord_t              box_w,
  input  coord_t              box_h,
  input  logic [DATAW-1:0]    color,
  video_box_overlay_if.slave  s_axis,
  video_box_overlay_if.master m_axis,
  output logic [DATAW/8-1:0]  m_axis_tstrb,
  output logic [DATAW/8-1:0]  m_axis_tkeep,
  output logic                m_axis_tid,
  output logic                m_axis_tdest,
  output logic                err_early_eol,
  output logic                err_late_eol,
  output logic                err_early_sof,
  output logic [FCNT_W-1:0]   frame_cnt
);
  localparam int PW = DATAW + 2;
  localparam logic [COORD_W:0] BRD = (COORD_W+1)'(BORDER);

  function automatic logic [COORD_W:0] ext(input coord_t v);
    return {1'b0, v};
  endfunction

  function automatic coord_t sat_inc(input coord_t v);
    return (v == COORD_MAX) ? v : v + coord_t'(1);
  endfunction

  vstate_e state;
  coord_t  x, y, bx_q, by_q, bw_q, bh_q;

  logic             acc_p0, sof_p0, eol_p0, vld_p0, inside_p0, border_p0;
  coord_t           cx_p0, cy_p0, bx_p0, by_p0, bw_p0, bh_p0;
  logic [COORD_W:0] r_edge_p0, b_edge_p0;
  logic [DATAW-1:0] pix_p0;
  logic [PW-1:0]    beat_p0, beat_p1;

  // Stage 0: coordinates of the accepted beat; a SOF beat is (0,0) with the live box.
  assign acc_p0 = s_axis.tvalid && s_axis.tready;
  assign sof_p0 = s_axis.tuser;
  assign eol_p0 = s_axis.tlast;
  assign vld_p0 = s_axis.tvalid && (state == ACTIVE || sof_p0);

  assign cx_p0 = sof_p0 ? '0    : x;
  assign cy_p0 = sof_p0 ? '0    : y;
  assign bx_p0 = sof_p0 ? box_x : bx_q;
  assign by_p0 = sof_p0 ? box_y : by_q;
  assign bw_p0 = sof_p0 ? box_w : bw_q;
  assign bh_p0 = sof_p0 ? box_h : bh_q;

  assign r_edge_p0 = ext(bx_p0) + ext(bw_p0);
  assign b_edge_p0 = ext(by_p0) + ext(bh_p0);
  assign inside_p0 = ext(cx_p0) >= ext(bx_p0) && ext(cx_p0) < r_edge_p0 &&
                     ext(cy_p0) >= ext(by_p0) && ext(cy_p0) < b_edge_p0;
  assign border_p0 = inside_p0 &&
                     (ext(cx_p0) < ext(bx_p0) + BRD || ext(cx_p0) + BRD >= r_edge_p0 ||
                      ext(cy_p0) < ext(by_p0) + BRD || ext(cy_p0) + BRD >= b_edge_p0);
  assign pix_p0    = (en && border_p0) ? color : s_axis.tdata;
  assign beat_p0   = {sof_p0, eol_p0, pix_p0};

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= WAIT_SOF;
      x             <= '0;
      y             <= '0;
      bx_q          <= '0;
      by_q          <= '0;
      bw_q          <= '0;
      bh_q          <= '0;
      frame_cnt     <= '0;
      err_early_eol <= 1'b0;
      err_late_eol  <= 1'b0;
      err_early_sof <= 1'b0;
    end else begin
      err_early_eol <= 1'b0;
      err_late_eol  <= 1'b0;
      err_early_sof <= 1'b0;
      if (acc_p0 && (state == ACTIVE || sof_p0)) begin
        if (sof_p0) begin
          frame_cnt     <= frame_cnt + FCNT_W'(1);
          bx_q          <= box_x;
          by_q          <= box_y;
          bw_q          <= box_w;
          bh_q          <= box_h;
          err_early_sof <= (state == ACTIVE);
        end
        if (eol_p0) begin
          err_early_eol <= cx_p0 < coord_t'(SCRW - 1);
          x             <= '0;
          if (cy_p0 == coord_t'(SCRH - 1)) begin
            state <= WAIT_SOF;
            y     <= '0;
          end else begin
            state <= ACTIVE;
            y     <= cy_p0 + coord_t'(1);
          end
        end else begin
          // Past the last column x keeps counting (saturating) until tlast arrives.
          err_late_eol <= (cx_p0 == coord_t'(SCRW - 1));
          x            <= sat_inc(cx_p0);
          y            <= cy_p0;
          state        <= ACTIVE;
        end
      end
    end
  end

  // Stage 1: output register.
  axis_reg_slice #(.W(PW)) u_slice (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (vld_p0),
    .in_ready  (s_axis.tready),
    .in_data   (beat_p0),
    .out_valid (m_axis.tvalid),
    .out_ready (m_axis.tready),
    .out_data  (beat_p1)
  );

  assign {m_axis.tuser, m_axis.tlast, m_axis.tdata} = beat_p1;
  assign m_axis_tstrb = '1;
  assign m_axis_tkeep = '1;
  assign m_axis_tid   = 1'b0;
  assign m_axis_tdest = 1'b0;
endmodule

// File: tb/tb_video_box_overlay.sv
// Directed bench for video_box_overlay on an 8x4 screen with a 1-pixel border.
module tb_video_box_overlay;
  localparam int DATAW = 24, SCRW = 8, SCRH = 4, BORDER = 1;
  localparam logic [23:0] COLOR = 24'hFF00FF;
  typedef logic [25:0] beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b1;
  logic [12:0] box_x = 13'd2, box_y = 13'd1, box_w = 13'd4, box_h = 13'd3;
  logic [23:0] color = COLOR;
  logic [2:0]  tstrb, tkeep;
  logic        tid, tdest, e_eol, l_eol, e_sof;
  logic [15:0] frame_cnt;

  video_box_overlay_if #(.DATAW(DATAW)) s_axis ();
  video_box_overlay_if #(.DATAW(DATAW)) m_axis ();

  video_box_overlay #(.DATAW(DATAW), .SCRW(SCRW), .SCRH(SCRH), .BORDER(BORDER)) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .box_x         (box_x),
    .box_y         (box_y),
    .box_w         (box_w),
    .box_h         (box_h),
    .color         (color),
    .s_axis        (s_axis),
    .m_axis        (m_axis),
    .m_axis_tstrb  (tstrb),
    .m_axis_tkeep  (tkeep),
    .m_axis_tid    (tid),
    .m_axis_tdest  (tdest),
    .err_early_eol (e_eol),
    .err_late_eol  (l_eol),
    .err_early_sof (e_sof),
    .frame_cnt     (frame_cnt)
  );

  always #5 clk = ~clk;

  int rdy_mode = 0;
  always @(posedge clk) begin
    #1;
    m_axis.tready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(1)) : 1'b0;
  end

  beat_t out_q[$];
  int    n_early_eol = 0, n_late_eol = 0, n_early_sof = 0, stall_bad = 0;
  logic  hold_prev = 1'b0;
  beat_t prev_beat = '0;

  always @(negedge clk) begin
    if (m_axis.tvalid === 1'b1 && m_axis.tready === 1'b1)
      out_q.push_back({m_axis.tuser, m_axis.tlast, m_axis.tdata});
    if (hold_prev && (m_axis.tvalid !== 1'b1 || {m_axis.tuser, m_axis.tlast, m_axis.tdata} !== prev_beat))
      stall_bad <= stall_bad + 1;
    hold_prev <= (m_axis.tvalid === 1'b1 && m_axis.tready === 1'b0);
    prev_beat <= {m_axis.tuser, m_axis.tlast, m_axis.tdata};
    if (e_eol === 1'b1) n_early_eol <= n_early_eol + 1;
    if (l_eol === 1'b1) n_late_eol  <= n_late_eol + 1;
    if (e_sof === 1'b1) n_early_sof <= n_early_sof + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  int    n_pass = 0, n_total = 0, n_fail = 0;
  beat_t exp_q[$];
  int    base = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Box (2,1,4,3) with BORDER=1: columns 2..5, lines 1..3, border on its outline.
  function automatic logic border_at(input int px, input int py);
    logic in_box;
    in_box = (px >= 2 && px <= 5 && py >= 1 && py <= 3);
    return in_box && (px == 2 || px == 5 || py == 1 || py == 3);
  endfunction

  task automatic send(input int px, input int py, input logic u, input logic l,
                      input logic fwd, input logic gaps);
    logic [23:0] d;
    logic        took;
    int          guard;
    d = {8'(py), 8'(px), 8'h00};
    if (gaps) repeat ($urandom_range(2)) begin @(posedge clk); #1; end
    s_axis.tdata  = d;
    s_axis.tuser  = u;
    s_axis.tlast  = l;
    s_axis.tvalid = 1'b1;
    took  = 1'b0;
    guard = 0;
    while (!took && guard < 200) begin
      @(negedge clk);
      took = (s_axis.tready === 1'b1);
      @(posedge clk);
      #1;
      guard++;
    end
    s_axis.tvalid = 1'b0;
    chk("accept", 32'(took), 32'd1);
    if (fwd) exp_q.push_back({u, l, (en && border_at(px, py)) ? COLOR : d});
  endtask

  task automatic send_frame(input logic gaps, input logic lat);
    for (int yy = 0; yy < SCRH; yy++)
      for (int xx = 0; xx < SCRW; xx++) begin
        send(xx, yy, xx == 0 && yy == 0, xx == SCRW - 1, 1'b1, gaps);
        if (lat) begin
          chk("latency_vld", 32'(m_axis.tvalid), 32'd1);
          chk("latency_beat", 32'({m_axis.tuser, m_axis.tlast, m_axis.tdata}), 32'(exp_q[$]));
        end
      end
  endtask

  task automatic check_stream(input string tag);
    int n;
    rdy_mode = 0;
    repeat (6) @(posedge clk);
    #1;
    n = out_q.size() - base;
    chk({tag, "_count"}, 32'(n), 32'(exp_q.size()));
    for (int i = 0; i < n && i < exp_q.size(); i++)
      chk($sformatf("%s_beat%0d", tag, i), 32'(out_q[base + i]), 32'(exp_q[i]));
    base = out_q.size();
    exp_q.delete();
  endtask

  int e0, l0, s0, sz;

  initial begin
    s_axis.tvalid = 1'b0;
    s_axis.tdata  = '0;
    s_axis.tuser  = 1'b0;
    s_axis.tlast  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", 32'(m_axis.tvalid), 32'd0);
    chk("rst_tuser", 32'(m_axis.tuser), 32'd0);
    chk("rst_tlast", 32'(m_axis.tlast), 32'd0);
    chk("rst_tdata", 32'(m_axis.tdata), 32'd0);
    chk("rst_errs", 32'({e_eol, l_eol, e_sof}), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("const_strb_keep", 32'({tstrb, tkeep}), 32'h3F);
    chk("const_id_dest", 32'({tid, tdest}), 32'd0);
    rst = 1'b0;

    // Two overlay frames at full rate, the first with per-beat latency checks.
    send_frame(1'b0, 1'b1);
    send_frame(1'b0, 1'b0);
    check_stream("ovl");
    chk("ovl_frame_cnt", 32'(frame_cnt), 32'd2);
    chk("ovl_no_errs", 32'(n_early_eol + n_late_eol + n_early_sof), 32'd0);

    en = 1'b0;
    send_frame(1'b0, 1'b0);
    check_stream("thru");
    chk("thru_frame_cnt", 32'(frame_cnt), 32'd3);
    en = 1'b1;

    // Random sink stalls and source gaps.
    rdy_mode = 1;
    send_frame(1'b1, 1'b0);
    send_frame(1'b1, 1'b0);
    check_stream("stall");
    chk("stall_stable", 32'(stall_bad), 32'd0);
    chk("stall_frame_cnt", 32'(frame_cnt), 32'd5);

    // Line 1 ends early at x=5.
    e0 = n_early_eol; l0 = n_late_eol;
    for (int xx = 0; xx < 8; xx++) send(xx, 0, xx == 0, xx == 7, 1'b1, 1'b0);
    for (int xx = 0; xx < 6; xx++) send(xx, 1, 1'b0, xx == 5, 1'b1, 1'b0);
    for (int yy = 2; yy < 4; yy++)
      for (int xx = 0; xx < 8; xx++) send(xx, yy, 1'b0, xx == 7, 1'b1, 1'b0);
    check_stream("eeol");
    chk("eeol_pulses", 32'(n_early_eol - e0), 32'd1);
    chk("eeol_no_late", 32'(n_late_eol - l0), 32'd0);
    chk("eeol_frame_cnt", 32'(frame_cnt), 32'd6);

    // Line 0 is 9 pixels long.
    e0 = n_early_eol; l0 = n_late_eol;
    for (int xx = 0; xx < 9; xx++) send(xx, 0, xx == 0, xx == 8, 1'b1, 1'b0);
    for (int yy = 1; yy < 4; yy++)
      for (int xx = 0; xx < 8; xx++) send(xx, yy, 1'b0, xx == 7, 1'b1, 1'b0);
    check_stream("leol");
    chk("leol_pulses", 32'(n_late_eol - l0), 32'd1);
    chk("leol_no_early", 32'(n_early_eol - e0), 32'd0);
    chk("leol_frame_cnt", 32'(frame_cnt), 32'd7);

    // Fresh reset, garbage before SOF, then a SOF in the middle of line 2.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    e0 = n_early_eol; l0 = n_late_eol; s0 = n_early_sof;
    for (int i = 0; i < 3; i++) send(i, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_stream("garbage");
    chk("garbage_frame_cnt", 32'(frame_cnt), 32'd0);
    for (int yy = 0; yy < 2; yy++)
      for (int xx = 0; xx < 8; xx++) send(xx, yy, xx == 0 && yy == 0, xx == 7, 1'b1, 1'b0);
    for (int xx = 0; xx < 3; xx++) send(xx, 2, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(1'b0, 1'b0);
    check_stream("esof");
    chk("esof_pulses", 32'(n_early_sof - s0), 32'd1);
    chk("esof_no_eol_errs", 32'((n_early_eol - e0) + (n_late_eol - l0)), 32'd0);
    chk("esof_frame_cnt", 32'(frame_cnt), 32'd2);

    // Reset while a beat is held by a stalled sink.
    send(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rdy_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    send(1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("held_tvalid", 32'(m_axis.tvalid), 32'd1);
    chk("held_tdata", 32'(m_axis.tdata), 32'h000100);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_tvalid", 32'(m_axis.tvalid), 32'd0);
    chk("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("midrst_tready", 32'(s_axis.tready), 32'd1);
    rst = 1'b0;
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    sz = out_q.size();
    send(2, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_wait_sof", 32'(out_q.size() - sz), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
